// File: rtl/fetch_pkg.sv
// Shared fetch encodings: pc_sel values (also used by the branch-logic block),
// fetch FSM states and the default boot address.
package fetch_pkg;

    typedef enum logic [2:0] {
        PC_4   = 3'd0,
        PC_BR  = 3'd1,
        PC_J   = 3'd2,
        PC_JR  = 3'd3,
        PC_EXC = 3'd4
    } pc_sel_e;

    typedef enum logic [1:0] {
        BOOT = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_2000;

endpackage

// File: rtl/if_kill_counter.sv
// Squash-pulse generator: a load produces exactly KILL_CYCLES consecutive kill
// cycles, the load cycle included; a reload restarts the run without accumulating.
module if_kill_counter #(
    parameter int KILL_CYCLES = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic load,
    output logic kill
);

    logic [2:0] cnt_q, cnt_d;

    // Counter holds the kills still owed after the current cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (load)
            cnt_d = 3'(KILL_CYCLES - 1);
        else if (cnt_q != 3'd0)
            cnt_d = cnt_q - 3'd1;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= 3'd0;
        else        cnt_q <= cnt_d;
    end

    assign kill = load || (cnt_q != 3'd0);

endmodule

// File: rtl/fetch_redirect_ctrl.sv
// Fetch PC sequencer: redirect target mux, BOOT/RUN/PEND FSM, imem handshake.
// Define FETCH_MISALIGN_TRAP_EN to divert misaligned BR/JMP/JALR targets to io_evec.
module fetch_redirect_ctrl
    import fetch_pkg::*;
#(
    parameter int              XLEN        = 32,
    parameter logic [XLEN-1:0] RESET_PC    = XLEN'(RESET_PC_DEFAULT),
    parameter int              KILL_CYCLES = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [2:0]      io_pc_sel,
    input  logic            io_exe_valid,
    input  logic [XLEN-1:0] io_br_target,
    input  logic [XLEN-1:0] io_jmp_target,
    input  logic [XLEN-1:0] io_jalr_target,
    input  logic [XLEN-1:0] io_evec,
    output logic            io_imem_req_valid,
    input  logic            io_imem_req_ready,
    output logic [XLEN-1:0] io_imem_req_addr,
    output logic            io_if_kill,
`ifdef FETCH_MISALIGN_TRAP_EN
    output logic            io_misalign_excp,
`endif
    output logic            io_redirect_busy
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    fetch_state_e    state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pend_q, pend_d;
    logic [XLEN-1:0] tgt;
    logic            sel_redir;
    logic            redirect;

    always_comb begin
        tgt       = io_br_target;
        sel_redir = 1'b0;
        case (io_pc_sel)
            PC_BR:   begin tgt = io_br_target;  sel_redir = 1'b1; end
            PC_J:    begin tgt = io_jmp_target; sel_redir = 1'b1; end
            PC_JR:   begin tgt = io_jalr_target & ~XLEN'(1); sel_redir = 1'b1; end
            PC_EXC:  begin tgt = io_evec;       sel_redir = 1'b1; end
            default: ;
        endcase
`ifdef FETCH_MISALIGN_TRAP_EN
        if (sel_redir && io_pc_sel != PC_EXC && tgt[1:0] != 2'b00)
            tgt = io_evec;
`endif
    end

    // Redirects are ignored in BOOT so every output stays low through reset.
    assign redirect = io_exe_valid && sel_redir && (state_q != BOOT);

`ifdef FETCH_MISALIGN_TRAP_EN
    always_comb begin
        io_misalign_excp = 1'b0;
        case (io_pc_sel)
            PC_BR:   io_misalign_excp = redirect && (io_br_target[1:0]   != 2'b00);
            PC_J:    io_misalign_excp = redirect && (io_jmp_target[1:0]  != 2'b00);
            PC_JR:   io_misalign_excp = redirect &&  io_jalr_target[1];
            default: ;
        endcase
    end
`endif

    always_comb begin
        state_d           = state_q;
        pc_d              = pc_q;
        pend_d            = pend_q;
        io_imem_req_valid = 1'b0;
        io_imem_req_addr  = pc_q;
        io_redirect_busy  = 1'b0;
        case (state_q)
            BOOT: state_d = RUN;
            RUN: begin
                io_imem_req_valid = 1'b1;
                if (redirect) begin
                    io_imem_req_addr = tgt;
                    if (io_imem_req_ready) begin
                        pc_d = tgt + PC_STEP;
                    end else begin
                        pend_d  = tgt;
                        state_d = PEND;
                    end
                end else if (io_imem_req_ready) begin
                    pc_d = pc_q + PC_STEP;
                end
            end
            PEND: begin
                io_imem_req_valid = 1'b1;
                io_redirect_busy  = 1'b1;
                io_imem_req_addr  = redirect ? tgt : pend_q;
                if (redirect) pend_d = tgt;
                if (io_imem_req_ready) begin
                    pc_d    = io_imem_req_addr + PC_STEP;
                    state_d = RUN;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= BOOT;
            pc_q    <= RESET_PC;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            pend_q  <= pend_d;
        end
    end

    if_kill_counter #(.KILL_CYCLES(KILL_CYCLES)) u_kill (
        .clk   (clk),
        .reset (reset),
        .load  (redirect),
        .kill  (io_if_kill)
    );

endmodule

// File: tb/tb_fetch_redirect_ctrl.sv
// Scoreboard bench for fetch_redirect_ctrl: stimulus pushes hand-computed
// per-cycle expectations, a negedge monitor pops and compares.
module tb_fetch_redirect_ctrl;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [2:0]  pc_sel = 3'd0;
    logic        exe_valid = 1'b0;
    logic [31:0] br_t = '0, jmp_t = '0, jalr_t = '0;
    logic [31:0] evec = 32'h0000_0100;
    logic        req_valid, req_ready = 1'b1;
    logic [31:0] req_addr;
    logic        if_kill, busy;
    logic        misalign;

    always #5 clk = ~clk;

    fetch_redirect_ctrl dut (
        .clk               (clk),
        .reset             (reset),
        .io_pc_sel         (pc_sel),
        .io_exe_valid      (exe_valid),
        .io_br_target      (br_t),
        .io_jmp_target     (jmp_t),
        .io_jalr_target    (jalr_t),
        .io_evec           (evec),
        .io_imem_req_valid (req_valid),
        .io_imem_req_ready (req_ready),
        .io_imem_req_addr  (req_addr),
        .io_if_kill        (if_kill),
`ifdef FETCH_MISALIGN_TRAP_EN
        .io_misalign_excp  (misalign),
`endif
        .io_redirect_busy  (busy)
    );

`ifndef FETCH_MISALIGN_TRAP_EN
    assign misalign = 1'b0;
`endif

    typedef struct {
        int          id;
        logic        v;
        logic [31:0] a;
        logic        k;
        logic        b;
        logic        m;
    } exp_t;

    exp_t q[$];
    int   n_chk  = 0;
    int   n_fail = 0;
    int   step_id = 0;

    // One cycle: drive inputs, push the expected outputs for this cycle, advance.
    task automatic step(input logic ev, input logic [2:0] sel, input logic [31:0] t,
                        input logic rdy, input logic xv, input logic [31:0] xa,
                        input logic xk, input logic xb, input logic xm);
        exp_t e;
        exe_valid = ev; pc_sel = sel; br_t = t; jmp_t = t; jalr_t = t; req_ready = rdy;
        e.id = step_id; e.v = xv; e.a = xa; e.k = xk; e.b = xb; e.m = xm;
        q.push_back(e);
        step_id++;
        @(posedge clk); #1;
    endtask

    task automatic check_reset(input string nm);
        n_chk++;
        if (req_valid !== 1'b0 || req_addr !== 32'h2000 || if_kill !== 1'b0 ||
            busy !== 1'b0 || misalign !== 1'b0) begin
            n_fail++;
            $display("FAIL %s: got v=%b a=%h k=%b b=%b m=%b, want v=0 a=00002000 k=0 b=0 m=0",
                     nm, req_valid, req_addr, if_kill, busy, misalign);
        end
    endtask

    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_chk++;
            if (req_valid !== e.v || req_addr !== e.a || if_kill !== e.k ||
                busy !== e.b || misalign !== e.m) begin
                n_fail++;
                $display("FAIL step%0d: got v=%b a=%h k=%b b=%b m=%b, want v=%b a=%h k=%b b=%b m=%b",
                         e.id, req_valid, req_addr, if_kill, busy, misalign,
                         e.v, e.a, e.k, e.b, e.m);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, queue=%0d", q.size());
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $fatal(1);
    end

    initial begin
        logic [31:0] mis_a0, mis_a1, mis_a2;
        logic        mis_p;
        repeat (2) @(posedge clk);
        #1;
        exe_valid = 1'b1; pc_sel = 3'd4;     // redirect request must not leak through reset
        #1;
        check_reset("reset_state");
        exe_valid = 1'b0; pc_sel = 3'd0;
        reset = 1'b1;
        // Boot and sequential fetch
        step(0, 0, 32'h0, 1, 0, 32'h2000, 0, 0, 0);
        step(0, 0, 32'h0, 1, 1, 32'h2000, 0, 0, 0);
        step(0, 0, 32'h0, 1, 1, 32'h2004, 0, 0, 0);
        // Branch with ready: bypass, then target+4, two kill cycles
        step(1, 1, 32'h2100, 1, 1, 32'h2100, 1, 0, 0);
        step(0, 0, 32'h0, 1, 1, 32'h2104, 1, 0, 0);
        step(0, 0, 32'h0, 1, 1, 32'h2108, 0, 0, 0);
        step(0, 0, 32'h0, 1, 1, 32'h210C, 0, 0, 0);
        // JAL while imem stalls: held in PEND
        step(1, 2, 32'h3000, 0, 1, 32'h3000, 1, 0, 0);
        step(0, 0, 32'h0, 0, 1, 32'h3000, 1, 1, 0);
        step(0, 0, 32'h0, 0, 1, 32'h3000, 0, 1, 0);
        step(0, 0, 32'h0, 0, 1, 32'h3000, 0, 1, 0);
        step(0, 0, 32'h0, 1, 1, 32'h3000, 0, 1, 0);
        step(0, 0, 32'h0, 1, 1, 32'h3004, 0, 0, 0);
        // Exception overrides a pending redirect, kill reloads
        step(1, 2, 32'h5000, 0, 1, 32'h5000, 1, 0, 0);
        step(0, 0, 32'h0, 0, 1, 32'h5000, 1, 1, 0);
        step(1, 4, 32'h0, 0, 1, 32'h0100, 1, 1, 0);
        step(0, 0, 32'h0, 0, 1, 32'h0100, 1, 1, 0);
        step(0, 0, 32'h0, 1, 1, 32'h0100, 0, 1, 0);
        step(0, 0, 32'h0, 1, 1, 32'h0104, 0, 0, 0);
        // Override in PEND with ready in the same cycle; JALR clears bit0
        step(1, 1, 32'h6000, 0, 1, 32'h6000, 1, 0, 0);
        step(1, 3, 32'h4001, 1, 1, 32'h4000, 1, 1, 0);
        step(0, 0, 32'h0, 1, 1, 32'h4004, 1, 0, 0);
        step(0, 0, 32'h0, 1, 1, 32'h4008, 0, 0, 0);
        // Misaligned branch target
`ifdef FETCH_MISALIGN_TRAP_EN
        mis_a0 = 32'h0100; mis_a1 = 32'h0104; mis_a2 = 32'h0108; mis_p = 1'b1;
`else
        mis_a0 = 32'h4002; mis_a1 = 32'h4006; mis_a2 = 32'h400A; mis_p = 1'b0;
`endif
        step(1, 1, 32'h4002, 1, 1, mis_a0, 1, 0, mis_p);
        step(0, 0, 32'h0, 1, 1, mis_a1, 1, 0, 0);
        step(0, 0, 32'h0, 1, 1, mis_a2, 0, 0, 0);
        // PC wraps modulo 2^32
        step(1, 2, 32'hFFFF_FFFC, 1, 1, 32'hFFFF_FFFC, 1, 0, 0);
        step(0, 0, 32'h0, 1, 1, 32'h0000_0000, 1, 0, 0);
        step(0, 0, 32'h0, 1, 1, 32'h0000_0004, 0, 0, 0);
        // pc_sel 5 is PC4; a branch without exe_valid is ignored
        step(1, 5, 32'h7777_0000, 1, 1, 32'h0000_0008, 0, 0, 0);
        step(0, 1, 32'h7777_0000, 1, 1, 32'h0000_000C, 0, 0, 0);
        // Plain stall in RUN keeps the address
        step(0, 0, 32'h0, 0, 1, 32'h0000_0010, 0, 0, 0);
        step(0, 0, 32'h0, 0, 1, 32'h0000_0010, 0, 0, 0);
        step(0, 0, 32'h0, 1, 1, 32'h0000_0010, 0, 0, 0);
        step(0, 0, 32'h0, 1, 1, 32'h0000_0014, 0, 0, 0);
        // Reset mid-PEND
        step(1, 2, 32'h7000, 0, 1, 32'h7000, 1, 0, 0);
        step(0, 0, 32'h0, 0, 1, 32'h7000, 1, 1, 0);
        #2;
        reset = 1'b0;
        #1;
        check_reset("async_reset_mid_pend");
        @(posedge clk); #1;
        reset = 1'b1;
        step(0, 0, 32'h0, 1, 0, 32'h2000, 0, 0, 0);
        step(0, 0, 32'h0, 1, 1, 32'h2000, 0, 0, 0);
        step(0, 0, 32'h0, 1, 1, 32'h2004, 0, 0, 0);
        if (q.size() != 0) begin
            @(negedge clk); #1;
        end
        if (q.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
